// File: rtl/gift_round_controller.sv
// gift_round_controller
//   Iterative sequencer for a GIFT-128 one-round datapath. It holds the cipher
//   state, the key state, the 6-bit round-constant LFSR and the round counter.
//   It presents them to an external combinational round function and commits
//   that function's result once per cycle for ROUNDS rounds.
//
// Ports
//   inClk            clock; all state changes on the rising edge
//   inRst            synchronous active-high reset; overrides every other input
//   inStart          start request; accepted in IDLE or DONE only
//   inPlaintext      plaintext; loaded on an accepted start
//   inKey            master key; loaded on an accepted start
//   inAck            host acknowledge of the result; used in DONE only
//   inRoundResult    round-function output for the current data/key/constant
//   outRoundData     cipher state register; feeds the round function
//   outRoundKey      key state register (U = [95:64], V = [31:0])
//   outRoundConstant round-constant register
//   outBusy          high while rounds are running
//   outValid         high in DONE; outCiphertext is valid
//   outCiphertext    final cipher state
module gift_round_controller #(
    parameter int ROUNDS = 40
) (
    input  logic         inClk,
    input  logic         inRst,
    input  logic         inStart,
    input  logic [127:0] inPlaintext,
    input  logic [127:0] inKey,
    input  logic         inAck,
    input  logic [127:0] inRoundResult,
    output logic [127:0] outRoundData,
    output logic [127:0] outRoundKey,
    output logic [5:0]   outRoundConstant,
    output logic         outBusy,
    output logic         outValid,
    output logic [127:0] outCiphertext
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    state_t       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_q, key_d;
    logic [127:0] ct_q, ct_d;
    logic [5:0]   rc_q, rc_d;
    logic [5:0]   cnt_q, cnt_d;

    // Key update: the two low 16-bit words are rotated and moved to the top,
    // every other word shifts down by two word positions.
    function automatic logic [127:0] key_schedule(input logic [127:0] k);
        logic [15:0] k0, k1;
        k0 = k[15:0];
        k1 = k[31:16];
        return {{k1[1:0], k1[15:2]}, {k0[11:0], k0[15:12]}, k[127:32]};
    endfunction

    function automatic logic [5:0] rc_advance(input logic [5:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        ct_d    = ct_q;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A start in DONE takes priority over a simultaneous ack.
                if (inStart) begin
                    data_d  = inPlaintext;
                    key_d   = inKey;
                    rc_d    = 6'h01;
                    cnt_d   = 6'd0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE && inAck) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                data_d = inRoundResult;
                key_d  = key_schedule(key_q);
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == LAST_ROUND) begin
                    // Final round: capture the result and leave the constant
                    // at the value the last round used.
                    ct_d    = inRoundResult;
                    state_d = ST_DONE;
                end else begin
                    rc_d = rc_advance(rc_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            rc_q    <= 6'h00;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign outRoundData     = data_q;
    assign outRoundKey      = key_q;
    assign outRoundConstant = rc_q;
    assign outCiphertext    = ct_q;
    assign outBusy          = (state_q == ST_RUN);
    assign outValid         = (state_q == ST_DONE);

endmodule

// File: tb/tb_gift_round_controller.sv
// Testbench for gift_round_controller. Supplies the external round function
// (identity or real GIFT-128 round) and checks the controller against a
// behavioural encryption model.
module tb_gift_round_controller;

    localparam int           ROUNDS       = 40;
    localparam logic [63:0]  SBOX         = 64'hE805_7BD2_93F6_C4A1;
    localparam logic [127:0] GIFT_ZERO_CT = 128'hcd0bd738388ad3f668b15a36ceb6ff92;
    localparam logic [127:0] KEY1         = 128'h0000_0000_0000_0000_0000_0000_0004_0001;
    localparam logic [127:0] KEY1_NEXT    = 128'h0001_0010_0000_0000_0000_0000_0000_0000;

    logic         inClk = 1'b0;
    logic         inRst;
    logic         inStart;
    logic [127:0] inPlaintext;
    logic [127:0] inKey;
    logic         inAck;
    logic [127:0] inRoundResult;
    logic [127:0] outRoundData;
    logic [127:0] outRoundKey;
    logic [5:0]   outRoundConstant;
    logic         outBusy;
    logic         outValid;
    logic [127:0] outCiphertext;

    logic rf_real;

    int n_tests = 0;
    int n_fail  = 0;

    gift_round_controller #(.ROUNDS(ROUNDS)) dut (
        .inClk            (inClk),
        .inRst            (inRst),
        .inStart          (inStart),
        .inPlaintext      (inPlaintext),
        .inKey            (inKey),
        .inAck            (inAck),
        .inRoundResult    (inRoundResult),
        .outRoundData     (outRoundData),
        .outRoundKey      (outRoundKey),
        .outRoundConstant (outRoundConstant),
        .outBusy          (outBusy),
        .outValid         (outValid),
        .outCiphertext    (outCiphertext)
    );

    always #5 inClk = ~inClk;

    // GIFT-128 round: SubCells, PermBits, AddRoundKey (with constant)
    function automatic logic [127:0] gift_round(input logic [127:0] s, input logic [127:0] k,
                                                input logic [5:0] c);
        logic [127:0] t;
        logic [127:0] p;
        int           idx;
        t = '0;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            idx = int'(s[4*i +: 4]);
            t[4*i +: 4] = SBOX[4*idx +: 4];
        end
        for (int i = 0; i < 128; i++) begin
            idx = 4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
            p[idx] = t[i];
        end
        for (int i = 0; i < 32; i++) begin
            p[4*i+2] = p[4*i+2] ^ k[64+i];
            p[4*i+1] = p[4*i+1] ^ k[i];
        end
        for (int j = 0; j < 6; j++) p[4*j+3] = p[4*j+3] ^ c[j];
        p[127] = ~p[127];
        return p;
    endfunction

    always_comb inRoundResult = rf_real ? gift_round(outRoundData, outRoundKey, outRoundConstant)
                                        : outRoundData;

    function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
        return (x >> n) | (x << (16 - n));
    endfunction

    function automatic logic [127:0] ks_model(input logic [127:0] k);
        logic [15:0] w [8];
        for (int i = 0; i < 8; i++) w[i] = k[16*i +: 16];
        return {rotr16(w[1], 2), rotr16(w[0], 12), w[7], w[6], w[5], w[4], w[3], w[2]};
    endfunction

    function automatic logic [5:0] rc_model(input logic [5:0] c);
        int v;
        v = int'(c);
        v = ((v * 2) % 64) + (((v >> 5) ^ (v >> 4) ^ 1) & 1);
        return 6'(v);
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key,
                                                   input logic use_real);
        logic [127:0] s;
        logic [127:0] k;
        logic [5:0]   c;
        s = pt;
        k = key;
        c = 6'h01;
        for (int r = 1; r <= ROUNDS; r++) begin
            if (use_real) s = gift_round(s, k, c);
            k = ks_model(k);
            c = rc_model(c);
        end
        return s;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(negedge inClk);
    endtask

    // Returns at the first sample after the start edge.
    task automatic do_start(input logic [127:0] pt, input logic [127:0] key);
        inPlaintext = pt;
        inKey       = key;
        inStart     = 1'b1;
        cycle();
        inStart     = 1'b0;
    endtask

    // Sample index counts from 1 = first sample after the start edge.
    task automatic wait_valid(input int from, output int cyc);
        cyc = from;
        while (outValid !== 1'b1 && cyc < 200) begin
            cycle();
            cyc++;
        end
    endtask

    logic [127:0] pt, key, pt2, key2, kexp;
    logic [5:0]   rc_gold [6];
    int           cyc;
    logic         mode;

    initial begin
        rc_gold = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E};
        inRst = 1'b1; inStart = 1'b1; inAck = 1'b0; rf_real = 1'b0;
        inPlaintext = '1; inKey = '1;

        // Reset dominates a held start
        cycle(); cycle();
        check_eq("rst_busy", 128'(outBusy), 128'd0);
        check_eq("rst_valid", 128'(outValid), 128'd0);
        check_eq("rst_data", outRoundData, 128'd0);
        check_eq("rst_const", 128'(outRoundConstant), 128'd0);
        inRst = 1'b0; inStart = 1'b0;
        cycle(); cycle(); cycle();
        check_eq("idle_busy", 128'(outBusy), 128'd0);
        check_eq("idle_valid", 128'(outValid), 128'd0);

        // Constant sequence with identity round function
        pt = 128'h0123456789abcdef0123456789abcdef;
        do_start(pt, 128'h0);
        for (int k = 1; k <= ROUNDS; k++) begin
            if (k == 1) check_eq("run_busy", 128'(outBusy), 128'd1);
            if (k <= 6) check_eq($sformatf("const_r%0d", k), 128'(outRoundConstant), 128'(rc_gold[k-1]));
            if (k == ROUNDS) begin
                check_eq("const_r40", 128'(outRoundConstant), 128'h1a);
                check_eq("valid_early", 128'(outValid), 128'd0);
            end
            cycle();
        end
        check_eq("valid_at_41", 128'(outValid), 128'd1);
        check_eq("busy_done", 128'(outBusy), 128'd0);
        check_eq("ct_identity", outCiphertext, pt);
        check_eq("const_hold", 128'(outRoundConstant), 128'h1a);

        // DONE -> IDLE via ack
        inAck = 1'b1; cycle(); inAck = 1'b0;
        check_eq("ack_valid", 128'(outValid), 128'd0);
        check_eq("ack_busy", 128'(outBusy), 128'd0);
        check_eq("ack_ct_keep", outCiphertext, pt);
        cycle();
        check_eq("ack_idle", 128'(outBusy), 128'd0);

        // Key schedule with real round function
        rf_real = 1'b1;
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        do_start(pt, KEY1);
        check_eq("key_load", outRoundKey, KEY1);
        cycle();
        check_eq("key_upd1", outRoundKey, KEY1_NEXT);
        for (int k = 2; k <= 8; k++) cycle();
        kexp = KEY1;
        for (int k = 0; k < 8; k++) kexp = ks_model(kexp);
        check_eq("key_upd8", outRoundKey, kexp);
        wait_valid(9, cyc);
        check_eq("key_latency", 128'(cyc), 128'd41);
        check_eq("key_ct", outCiphertext, model_encrypt(pt, KEY1, 1'b1));
        check_eq("done_data_eq_ct", outRoundData, outCiphertext);

        // Start and ack together in DONE: start wins
        pt2  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        inAck = 1'b1;
        do_start(pt2, key2);
        inAck = 1'b0;
        check_eq("sa_busy", 128'(outBusy), 128'd1);
        check_eq("sa_valid", 128'(outValid), 128'd0);
        check_eq("sa_const", 128'(outRoundConstant), 128'h01);
        check_eq("sa_data", outRoundData, pt2);
        check_eq("sa_key", outRoundKey, key2);
        wait_valid(1, cyc);
        check_eq("sa_ct", outCiphertext, model_encrypt(pt2, key2, 1'b1));

        // Start pulse during RUN is ignored
        pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        do_start(pt, key);
        for (int k = 1; k < 10; k++) cycle();
        inPlaintext = ~pt; inKey = ~key; inStart = 1'b1; inAck = 1'b1;
        cycle();
        inStart = 1'b0; inAck = 1'b0;
        wait_valid(11, cyc);
        check_eq("ign_latency", 128'(cyc), 128'd41);
        check_eq("ign_ct", outCiphertext, model_encrypt(pt, key, 1'b1));

        // Reset in the middle of a run
        do_start(~pt, key);
        for (int k = 1; k < 20; k++) cycle();
        inRst = 1'b1; cycle(); inRst = 1'b0;
        check_eq("mrst_busy", 128'(outBusy), 128'd0);
        check_eq("mrst_valid", 128'(outValid), 128'd0);
        check_eq("mrst_data", outRoundData, 128'd0);
        check_eq("mrst_key", outRoundKey, 128'd0);
        check_eq("mrst_const", 128'(outRoundConstant), 128'd0);
        check_eq("mrst_ct", outCiphertext, 128'd0);

        // Official all-zero GIFT-128 vector
        do_start(128'd0, 128'd0);
        wait_valid(1, cyc);
        check_eq("zero_latency", 128'(cyc), 128'd41);
        check_eq("zero_ct_golden", outCiphertext, GIFT_ZERO_CT);
        check_eq("zero_ct_model", outCiphertext, model_encrypt(128'd0, 128'd0, 1'b1));

        // Randomized operations, ending either via ack or back-to-back start
        for (int it = 0; it < 8; it++) begin
            mode    = 1'($urandom_range(0, 1));
            rf_real = mode;
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            do_start(pt, key);
            wait_valid(1, cyc);
            check_eq($sformatf("rnd%0d_latency", it), 128'(cyc), 128'd41);
            check_eq($sformatf("rnd%0d_ct", it), outCiphertext, model_encrypt(pt, key, mode));
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) cycle();
            check_eq($sformatf("rnd%0d_hold", it), outCiphertext, model_encrypt(pt, key, mode));
            if ($urandom_range(0, 1) == 1) begin
                inAck = 1'b1; cycle(); inAck = 1'b0;
                check_eq($sformatf("rnd%0d_ackvalid", it), 128'(outValid), 128'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
